// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Serial UART transmitter. Each byte accepted on `load` goes out as a 10-bit
// frame: a start bit (0), eight data bits LSB first, then a stop bit (1).
// Every bit lasts CLKS_PER_BIT system clocks. All outputs are registered, so
// no input reaches `data_out` combinationally.
//
// Parameters:
//   CLKS_PER_BIT   clocks per serial bit, legal range 2..255 (default 16)
//
// Ports:
//   clk             in   system clock; all state changes on the rising edge
//   rst             in   synchronous, active-low reset
//   data_in[7:0]    in   byte to send; sampled only when a load is accepted
//   load            in   transmit request; accepted when busy is low
//   data_out        out  serial line; idle high
//   busy            out  high from the cycle after acceptance to the last
//                        stop-bit cycle
//   character_sent  out  one-cycle pulse in the cycle after a frame completes
// -----------------------------------------------------------------------------
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       load,
  output logic       data_out,
  output logic       busy,
  output logic       character_sent
);

  // Bit-time counter width is ceil(log2(CLKS_PER_BIT)). It is at least 1 bit
  // wide because the legal range starts at 2.
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_q,  line_d;
  logic          busy_q,  busy_d;
  logic          sent_q,  sent_d;
  logic          bit_end_s;

  assign bit_end_s = (cnt_q == CNT_LAST);

  // Next-state logic for the framing FSM and the line/status outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    sent_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (load) begin
          shift_d = data_in;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          sent_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // The line value is decoded from the *next* state so that the registered
    // output changes on the same edge as the state. This gives the one-cycle
    // latency from load to the start bit.
    case (state_d)
      S_IDLE:  begin line_d = 1'b1;       busy_d = 1'b0; end
      S_START: begin line_d = 1'b0;       busy_d = 1'b1; end
      S_DATA:  begin line_d = shift_d[0]; busy_d = 1'b1; end
      S_STOP:  begin line_d = 1'b1;       busy_d = 1'b1; end
      default: begin line_d = 1'b1;       busy_d = 1'b0; end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      sent_q  <= sent_d;
    end
  end

  assign data_out       = line_q;
  assign busy           = busy_q;
  assign character_sent = sent_q;

endmodule
